// File: rtl/keypad_debouncer_if.sv
// Key-code holding register handshake between the debouncer and the control FSM.
interface keypad_debouncer_if #(
  parameter int CW = 2
) ();
  logic          code_valid;
  logic [CW-1:0] code;
  logic          code_ack;
  logic          overrun;

  modport master (output code_valid, output code, output overrun, input code_ack);
  modport slave  (input code_valid, input code, input overrun, output code_ack);
endinterface

// File: rtl/keypad_debouncer.sv
// Front-panel button debouncer: 2-flop sync, per-button sample-counted debounce,
// press/release pulses and a one-deep key-code holding register.
// The release pulse port is named release_pulse because release is a reserved word.
module keypad_debouncer #(
  parameter int WIDTH  = 4,
  parameter int STABLE = 4
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [WIDTH-1:0] raw,
  input  logic             sample_key,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] press,
  output logic [WIDTH-1:0] release_pulse,
  keypad_debouncer_if.master hs
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [3:0] LAST = 4'(STABLE - 1);

  logic [WIDTH-1:0] sync1, raw_s;
  logic             sk_prev;
  logic             ev;
  logic [3:0]       cnt   [WIDTH];
  logic [3:0]       cnt_n [WIDTH];
  logic [WIDTH-1:0] level_n, press_n, rel_n;

  logic          cv_q, ov_q;
  logic [CW-1:0] code_q;
  logic [CW-1:0] low_idx;
  logic          found, multi, any_p, acc_ack, load;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      sync1   <= '0;
      raw_s   <= '0;
      sk_prev <= 1'b0;
    end else begin
      sync1   <= raw;
      raw_s   <= sync1;
      sk_prev <= sample_key;
    end
  end

  assign ev = sample_key & ~sk_prev;

  // Any agreeing sample restarts the run; the STABLE-th disagreeing sample commits.
  always_comb begin
    cnt_n   = cnt;
    level_n = level;
    press_n = '0;
    rel_n   = '0;
    if (ev) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (raw_s[i] == level[i]) begin
          cnt_n[i] = '0;
        end else if (cnt[i] == LAST) begin
          level_n[i] = raw_s[i];
          cnt_n[i]   = '0;
          press_n[i] = raw_s[i];
          rel_n[i]   = ~raw_s[i];
        end else begin
          cnt_n[i] = cnt[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      cnt           <= '{default: '0};
      level         <= '0;
      press         <= '0;
      release_pulse <= '0;
    end else begin
      cnt           <= cnt_n;
      level         <= level_n;
      press         <= press_n;
      release_pulse <= rel_n;
    end
  end

  always_comb begin
    low_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (press[i] && !found) begin
        low_idx = CW'(i);
        found   = 1'b1;
      end
    end
  end

  assign any_p   = |press;
  assign multi   = |(press & (press - WIDTH'(1)));
  assign acc_ack = cv_q & hs.code_ack;
  assign load    = any_p & (~cv_q | hs.code_ack);

  // Ack clears overrun first; a same-edge multi-bit load or a blocked press sets it again.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      cv_q   <= 1'b0;
      code_q <= '0;
      ov_q   <= 1'b0;
    end else begin
      if (load) begin
        cv_q   <= 1'b1;
        code_q <= low_idx;
      end else if (acc_ack) begin
        cv_q <= 1'b0;
      end
      if ((load && multi) || (any_p && cv_q && !hs.code_ack))
        ov_q <= 1'b1;
      else if (acc_ack)
        ov_q <= 1'b0;
    end
  end

  assign hs.code_valid = cv_q;
  assign hs.code       = code_q;
  assign hs.overrun    = ov_q;
endmodule

// File: tb/tb_keypad_debouncer.sv
// Directed scenarios for keypad_debouncer with a pulse-driven scoreboard monitor.
module tb_keypad_debouncer;
  logic       clk = 1'b0;
  logic       clear_n;
  logic [3:0] raw;
  logic       sample_key;
  logic [3:0] level, press, release_pulse;

  keypad_debouncer_if #(.CW(2)) hs ();

  keypad_debouncer #(.WIDTH(4), .STABLE(4)) dut (
    .clk           (clk),
    .clear_n       (clear_n),
    .raw           (raw),
    .sample_key    (sample_key),
    .level         (level),
    .press         (press),
    .release_pulse (release_pulse),
    .hs            (hs.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] p;
    logic [3:0] r;
    logic [3:0] lvl;
    logic       cv;
    logic [1:0] cd;
    logic       ov;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ev_cnt = 0;
  logic skq = 1'b0;
  logic busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Strobe: 3 clk high, 5 clk low.
  initial begin
    sample_key = 1'b0;
    forever begin
      @(posedge clk); #1 sample_key = 1'b1;
      repeat (2) @(posedge clk);
      @(posedge clk); #1 sample_key = 1'b0;
      repeat (4) @(posedge clk);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (sample_key && !skq) ev_cnt++;
      skq = sample_key;
    end
  end

  task automatic wait_ev(input int n);
    int target, guard;
    target = ev_cnt + n;
    guard  = 0;
    while (ev_cnt < target && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) check("wait_ev_timeout", 32'd1, 32'd0);
  endtask

  task automatic push(input logic [3:0] p, input logic [3:0] r, input logic [3:0] lvl,
                      input logic cv, input logic [1:0] cd, input logic ov);
    exp_t e;
    e.p = p; e.r = r; e.lvl = lvl; e.cv = cv; e.cd = cd; e.ov = ov;
    sb.push_back(e);
  endtask

  task automatic drain();
    int guard = 0;
    while ((sb.size() != 0 || busy) && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 300) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic ack_once();
    hs.code_ack = 1'b1;
    tick(1);
    hs.code_ack = 1'b0;
  endtask

  // Monitor: every pulse pops one expectation; handshake state is checked one cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if ((press | release_pulse) != 4'b0) begin
        busy = 1'b1;
        if (sb.size() == 0) begin
          check("unexpected_pulse", {press, release_pulse}, 8'h00);
        end else begin
          e = sb.pop_front();
          check("press", press, e.p);
          check("release", release_pulse, e.r);
          check("level", level, e.lvl);
          @(negedge clk);
          check("code_valid", hs.code_valid, e.cv);
          check("code", hs.code, e.cd);
          check("overrun", hs.overrun, e.ov);
        end
        busy = 1'b0;
      end
    end
  end

  initial begin
    int guard;
    clear_n     = 1'b0;
    raw         = 4'b0000;
    hs.code_ack = 1'b0;
    tick(4);
    check("rst_level", level, 4'b0);
    check("rst_cv", hs.code_valid, 1'b0);
    check("rst_ov", hs.overrun, 1'b0);
    clear_n = 1'b1;
    tick(20);

    // Clean press of key 2 with exact sample-event latency.
    raw = 4'b0100;
    tick(2);
    wait_ev(3);
    check("s2_level_before", level, 4'b0000);
    push(4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0);
    wait_ev(1);
    check("s2_level_after", level, 4'b0100);
    drain();
    tick(2);
    ack_once();
    check("s2_cv_after_ack", hs.code_valid, 1'b0);
    check("s2_code_hold", hs.code, 2'd2);

    // Bounce on key 1: every third sample reads 0.
    for (int k = 0; k < 9; k++) begin
      wait_ev(1);
      raw = (k % 3 == 2) ? 4'b0100 : 4'b0110;
    end
    wait_ev(1);
    raw = 4'b0100;
    wait_ev(5);
    check("s3_level", level, 4'b0100);
    check("s3_cv", hs.code_valid, 1'b0);

    // Release key 2.
    push(4'b0000, 4'b0100, 4'b0000, 1'b0, 2'd2, 1'b0);
    raw = 4'b0000;
    drain();

    // Simultaneous press of keys 1 and 3.
    push(4'b1010, 4'b0000, 4'b1010, 1'b1, 2'd1, 1'b1);
    raw = 4'b1010;
    drain();
    ack_once();
    check("s5_cv_after_ack", hs.code_valid, 1'b0);
    check("s5_ov_after_ack", hs.overrun, 1'b0);
    push(4'b0000, 4'b1010, 4'b0000, 1'b0, 2'd1, 1'b0);
    raw = 4'b0000;
    drain();

    // Full holding register, then a press accepted alongside an ack.
    push(4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b0);
    raw = 4'b0001;
    drain();
    push(4'b1000, 4'b0000, 4'b1001, 1'b1, 2'd0, 1'b1);
    raw = 4'b1001;
    drain();
    push(4'b0000, 4'b1000, 4'b0001, 1'b1, 2'd0, 1'b1);
    raw = 4'b0001;
    drain();
    push(4'b1000, 4'b0000, 4'b1001, 1'b1, 2'd3, 1'b0);
    raw = 4'b1001;
    guard = 0;
    while (press == 4'b0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) check("s6_press_timeout", 32'd1, 32'd0);
    ack_once();
    drain();

    push(4'b0000, 4'b1001, 4'b0000, 1'b1, 2'd3, 1'b0);
    raw = 4'b0000;
    drain();
    ack_once();
    check("s6_cv_after_ack", hs.code_valid, 1'b0);

    // Reset in the middle of a debounce.
    push(4'b0011, 4'b0000, 4'b0011, 1'b1, 2'd0, 1'b1);
    raw = 4'b0011;
    drain();
    raw = 4'b1111;
    tick(2);
    wait_ev(2);
    check("s1_level_pre", level, 4'b0011);
    #3 clear_n = 1'b0;
    #1;
    check("s1_rst_level", level, 4'b0);
    check("s1_rst_press", press, 4'b0);
    check("s1_rst_release", release_pulse, 4'b0);
    check("s1_rst_cv", hs.code_valid, 1'b0);
    check("s1_rst_code", hs.code, 2'd0);
    check("s1_rst_ov", hs.overrun, 1'b0);
    tick(3);
    clear_n = 1'b1;
    tick(2);
    wait_ev(3);
    check("s1_level_3ev", level, 4'b0000);
    push(4'b1111, 4'b0000, 4'b1111, 1'b1, 2'd0, 1'b1);
    wait_ev(1);
    check("s1_level_4ev", level, 4'b1111);
    drain();
    tick(4);
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
